// File: rtl/axi_multiplexer_pkg.sv
// Shared definitions for the per-packet stream split/merge blocks.
// Holds the bus width, the beat layout carried through the register slice,
// the FSM state enum and the stream-index width helper.
package axi_multiplexer_pkg;

  localparam int AXI_DATA_BITS = 64;
  localparam int AXI_KEEP_BITS = AXI_DATA_BITS / 8;

  typedef enum logic {
    IDLE    = 1'b0,
    FORWARD = 1'b1
  } mux_state_t;

  // One AXI4-Stream beat as it travels through the output slice.
  typedef struct packed {
    logic [AXI_DATA_BITS-1:0] tdata;
    logic [AXI_KEEP_BITS-1:0] tkeep;
    logic                     tlast;
  } axis_beat_t;

  localparam int AXIS_BEAT_BITS = $bits(axis_beat_t);

  // Width of a stream index; never collapses to zero bits.
  function automatic int stream_idx_bits(input int num_streams);
    return (num_streams > 1) ? $clog2(num_streams) : 1;
  endfunction

endpackage

// File: rtl/axi_skid_buffer.sv
// Generic 2-entry AXI4-Stream register slice (main + skid register).
// Latency: 1 cycle, full throughput while out_ready stays high.
// Backpressure: in_ready comes straight from a flop and drops the cycle after the skid entry fills.
module axi_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_vld;
  logic             skid_vld;
  logic [WIDTH-1:0] main_dat;
  logic [WIDTH-1:0] skid_dat;
  logic             in_fire;

  // Ready depends only on the skid flop, so out_ready never reaches in_ready combinationally.
  assign in_ready  = ~skid_vld;
  assign in_fire   = in_valid & ~skid_vld;
  assign out_valid = main_vld;
  assign out_data  = main_dat;

  // Main register refills from the skid entry first, otherwise from the input; the skid only catches a beat while the main register is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!main_vld || out_ready) begin
      if (skid_vld) begin
        main_dat <= skid_dat;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        main_vld <= in_fire;
        if (in_fire) main_dat <= in_data;
      end
    end else if (in_fire) begin
      skid_dat <= in_data;
      skid_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_multiplexer.sv
// Merges NUM_STREAMS AXI4-Stream inputs into one output, a whole packet at a time, in select-token order.
// Latency: 1 cycle input-to-output through a 2-entry register slice; back-to-back packets without bubbles.
// Backpressure: only the selected input sees the slice's registered ready; all other inputs are held off.
module axi_multiplexer
  import axi_multiplexer_pkg::*;
#(
  parameter int NUM_STREAMS = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     select_valid,
  output logic                                     select_ready,
  input  logic [$clog2(NUM_STREAMS)-1:0]           select_data,
  input  logic [NUM_STREAMS-1:0]                   in_tvalid,
  output logic [NUM_STREAMS-1:0]                   in_tready,
  input  logic [NUM_STREAMS-1:0][AXI_DATA_BITS-1:0] in_tdata,
  input  logic [NUM_STREAMS-1:0][AXI_KEEP_BITS-1:0] in_tkeep,
  input  logic [NUM_STREAMS-1:0]                   in_tlast,
  output logic                                     out_tvalid,
  input  logic                                     out_tready,
  output logic [AXI_DATA_BITS-1:0]                 out_tdata,
  output logic [AXI_KEEP_BITS-1:0]                 out_tkeep,
  output logic                                     out_tlast,
  output logic                                     sel_err
);

  localparam int IDX_BITS = stream_idx_bits(NUM_STREAMS);

  mux_state_t          state;
  logic [IDX_BITS-1:0] cur_sel;

  logic       forwarding;
  logic       buf_ready;
  logic       beat_fire;
  logic       last_fire;
  logic       sel_fire;
  logic       sel_in_range;
  axis_beat_t buf_in;
  axis_beat_t buf_out;

  // Reset gates every handshake so nothing is consumed while rst is held.
  assign forwarding   = (state == FORWARD) && !rst;
  assign buf_in       = {in_tdata[cur_sel], in_tkeep[cur_sel], in_tlast[cur_sel]};
  assign beat_fire    = forwarding && in_tvalid[cur_sel] && buf_ready;
  assign last_fire    = beat_fire && in_tlast[cur_sel];

  // A new token is taken while idle, or in the very cycle the current packet's last beat is accepted.
  assign select_ready = !rst && ((state == IDLE) || last_fire);
  assign sel_fire     = select_valid && select_ready;
  assign sel_in_range = int'(select_data) < NUM_STREAMS;
  assign sel_err      = sel_fire && !sel_in_range;

  // Only the active input is connected to the slice's ready.
  always_comb begin
    in_tready          = '0;
    in_tready[cur_sel] = forwarding && buf_ready;
  end

  // Packet-level FSM: latch a valid index, forward until tlast, then take the next token or go idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cur_sel <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_fire && sel_in_range) begin
            cur_sel <= select_data;
            state   <= FORWARD;
          end
        end
        FORWARD: begin
          if (last_fire) begin
            if (sel_fire && sel_in_range) cur_sel <= select_data;
            else                          state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  axi_skid_buffer #(
    .WIDTH(AXIS_BEAT_BITS)
  ) u_out_slice (
    .clk      (clk),
    .rst      (rst),
    .in_valid (beat_fire),
    .in_ready (buf_ready),
    .in_data  (buf_in),
    .out_valid(out_tvalid),
    .out_ready(out_tready),
    .out_data (buf_out)
  );

  assign out_tdata = buf_out.tdata;
  assign out_tkeep = buf_out.tkeep;
  assign out_tlast = buf_out.tlast;

endmodule

// File: doc/axi_multiplexer.md
# axi_multiplexer

Merges `NUM_STREAMS` AXI4 input streams into one output stream, one whole packet at a time. The order of packets is set by a select stream. Each select token names one input. That input's packet, up to and including its `tlast` beat, is forwarded to the output before the next token takes effect. The block is the merge side of the stream-split path: it recombines streams that were fanned out per packet, using the same select/index protocol as the split.

## Interface
Parameters:
- `NUM_STREAMS`, default 2 — number of input streams; must be ≥ 2.

Ports:
- `clk`  in  1 — the single clock.
- `rst`  in  1 — reset, synchronous and active-high.
- `select`  ready_valid_i.s  `$clog2(NUM_STREAMS)` data — stream of packet-source indices; one token per packet.
- `in[NUM_STREAMS]`  AXI4S.s  `AXI_DATA_BITS` tdata, `AXI_DATA_BITS/8` tkeep, tlast — input streams.
- `out`  AXI4S.m  same widths — merged output stream.
- `sel_err`  out  1 — one-cycle pulse when a select token with an index ≥ `NUM_STREAMS` is accepted.

## Operation
- The FSM has two states, `IDLE` and `FORWARD`, plus a register `cur_sel` that holds the active index.
- **IDLE:**
  - `select.ready = 1`.
  - On a select handshake with a valid index: latch `cur_sel` and go to `FORWARD`.
  - On a select handshake with an out-of-range index: discard the token, pulse `sel_err`, stay in `IDLE`.
- **FORWARD:**
  - Only `in[cur_sel]` is connected to the output stage: `in[cur_sel].tready` = output stage ready.
  - Every other `in[i].tready = 0`.
  - When the input beat carrying `tlast=1` completes its handshake:
    - `select.ready = 1` in that same cycle.
    - If a valid token is accepted in that cycle, load `cur_sel` with the new index and stay in `FORWARD` (back-to-back packets with no bubble).
    - Otherwise go to `IDLE`.
- In all other cycles `select.ready = 0`.
- Beats are forwarded unmodified: tdata, tkeep and tlast are copied bit-exact, and no beats are reordered or dropped.
- A packet of a single beat (`tlast=1` on the first beat) is legal and follows the same rules.
- Inputs that are not selected may hold `tvalid` high indefinitely; their beats are never consumed.

## Timing
- **Output stage:** a 2-entry skid register slice.
  - Input-to-output latency is 1 cycle.
  - Throughput is one beat per cycle when `out.tready` is held high.
  - Output ready is registered, so there is no combinational path from `out.tready` to `in[*].tready`.
- **Combinational paths that do exist:** `in[cur_sel].tvalid`/`tlast` → `select.ready`, and `select.valid`/data → `sel_err`.
- **Reset:** `rst` takes effect at the next rising edge of `clk` and dominates everything else.
  - State goes to `IDLE` and `cur_sel` to 0.
  - The skid buffer is emptied: `out.tvalid = 0`.
  - `sel_err = 0`.
- **Outputs while in reset:** `in[*].tready = 0` and `select.ready = 0`.
- **Reset in the middle of a packet:** the partial packet is abandoned, and any beats still held in the skid buffer are dropped. The upstream side is responsible for resynchronising.
- **Output backpressure:** with `out.tready = 0` the slice fills after 2 beats. `in[cur_sel].tready` drops in the cycle after the second entry is filled. No beat is lost or duplicated across the stall.
- **`tlast` beat stalled at the input:** the handover to the next select token happens only on the cycle the `tlast` beat actually completes its handshake, never earlier.

## Structure
- **Shared package (`libstf`):** the stream index typedef `stream_idx_t #(NUM_STREAMS)` (or an equivalent parameterised width helper) and the FSM state enum `mux_state_t`, so the split and merge blocks use the same definitions.
- **Taken from `lynxTypes`:** `AXI_DATA_BITS`.
- **Sub-module:** `axi_skid_buffer`, a generic 2-entry AXI4S register slice built on `ndata_i`. It is reusable elsewhere in the codebase.

## Test plan
- **Basic ordering:** `NUM_STREAMS=4`, select tokens 2,0,3. Each input sends a 3-beat packet with tdata = 0xA0+i, 0xB0+i, 0xC0+i. Required: the output carries the packets in order 2,0,3 — 9 beats with bit-exact data/keep, tlast on beats 3, 6 and 9.
- **Back-to-back throughput:** selects 1,1,0, each a single-beat packet, `out.tready = 1` throughout. Required: `out.tvalid` is high for 3 consecutive cycles starting 1 cycle after the first input handshake, with no idle cycles between packets.
- **Backpressure:** during a 5-beat packet, hold `out.tready = 0` for 4 cycles. Required: `in[sel].tready` falls once 2 beats are buffered; after release, all 5 beats arrive in order with none lost or duplicated.
- **Invalid index:** `NUM_STREAMS=3`, select token 3, then token 1. Required: `sel_err` pulses for exactly 1 cycle, no input is consumed for token 3, and then stream 1's packet is forwarded.
- **Isolation of unselected inputs:** `in[0]` and `in[2]` hold `tvalid` high; select token 1. Required: `in[0].tready = in[2].tready = 0` for the whole of stream 1's packet.
- **Reset mid-packet:** assert `rst` for 1 cycle on beat 2 of a 4-beat packet. Required: on the following cycle `out.tvalid = 0`, `select.ready = 1` and the FSM is in `IDLE`; a newly issued token 0 then forwards cleanly.
